shift_seq_ctrl: RTL and testbench

Sequencing stage that sits directly upstream of the 4-bit, 2-bit-amount barrel shifter step. It accepts whole shift commands with a direction and an amount of 0..15 over a valid/ready handshake, and splits each amount into shifter passes of at most 3 positions. It drives one pass per cycle to the shifter and loops the shifter result back into its data register. The final word is presented downstream on a second valid/ready handshake.

---
 rtl/shift_seq_pkg.sv | 8 +
 rtl/shift_amt_split.sv | 13 +
 rtl/shift_seq_ctrl.sv | 83 ++++++++
 tb/tb_shift_seq_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and constants for the shift sequencer
package shift_seq_pkg;
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  localparam int MAX_STEP = 3;
  localparam int SW = 2;
  localparam int DEF_DW = 4;
  localparam int DEF_AW = 4;
endpackage

// File: rtl/shift_amt_split.sv
// shift_amt_split: carves the next pass (at most MAX_STEP) off the remaining amount
module shift_amt_split import shift_seq_pkg::*; #(
  parameter int AW = DEF_AW
) (
  input  logic [AW-1:0] rem,
  output logic [SW-1:0] step_amt,
  output logic [AW-1:0] rem_next,
  output logic          last
);
  assign step_amt = (rem > AW'(MAX_STEP)) ? SW'(MAX_STEP) : rem[SW-1:0];
  assign rem_next = rem - AW'(step_amt);
  assign last = rem_next == '0;
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: splits shift commands into shifter passes of up to 3; SHIFT_SEQ_CLAMP_EN clamps amounts to DW
module shift_seq_ctrl import shift_seq_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_left,
  input  logic [AW-1:0] i_amt,
  input  logic [DW-1:0] i_data,
  output logic          o_step_valid,
  output logic          o_step_left,
  output logic [SW-1:0] o_step_amt,
  output logic [DW-1:0] o_step_data,
  input  logic [DW-1:0] i_step_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);
  state_t state, state_nxt;
  logic [AW-1:0] rem, rem_next, a_eff;
  logic [DW-1:0] dreg;
  logic [SW-1:0] step_amt;
  logic dir, last, accept;

  shift_amt_split #(.AW(AW)) u_split (
    .rem(rem),
    .step_amt(step_amt),
    .rem_next(rem_next),
    .last(last)
  );

  assign accept = i_valid & (state == IDLE);

`ifdef SHIFT_SEQ_CLAMP_EN
  // a logical shift by DW or more already yields zero, so larger amounts add only latency
  assign a_eff = (i_amt > AW'(DW)) ? AW'(DW) : i_amt;
`else
  assign a_eff = i_amt;
`endif

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else state <= state_nxt;
  end

  // command latch and pass loopback: shifter result replaces dreg each pass
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rem <= '0;
      dreg <= '0;
      dir <= 1'b0;
    end else if (accept) begin
      rem <= a_eff;
      dreg <= i_data;
      dir <= i_left;
    end else if (state == STEP) begin
      rem <= rem_next;
      dreg <= i_step_data;
    end
  end

  // next state; zero-amount commands skip straight to the result
  always_comb begin
    state_nxt = (state == IDLE) ? (i_valid ? ((a_eff == '0) ? DONE : STEP) : IDLE) :
                (state == STEP) ? (last ? DONE : STEP) :
                (i_ready ? IDLE : DONE);
  end

  // outputs decoded from state only, so no valid/ready combinational paths
  always_comb begin
    o_ready = state == IDLE;
    o_valid = state == DONE;
    o_step_valid = state == STEP;
    o_step_amt = o_step_valid ? step_amt : '0;
    o_step_left = o_step_valid & dir;
    o_step_data = dreg;
    o_data = dreg;
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed and random commands checked against a logical-shift model
module tb_shift_seq_ctrl;
  logic       i_clk = 0, i_rst = 1, i_valid = 0, i_left = 0, i_ready = 0;
  logic [3:0] i_amt = 0, i_data = 0, i_step_data, o_step_data, o_data;
  logic [1:0] o_step_amt;
  logic       o_ready, o_step_valid, o_step_left, o_valid;
  int total = 0, bad = 0;

  shift_seq_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_left(i_left), .i_amt(i_amt), .i_data(i_data),
    .o_step_valid(o_step_valid), .o_step_left(o_step_left), .o_step_amt(o_step_amt),
    .o_step_data(o_step_data), .i_step_data(i_step_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  // combinational logical shifter step
  assign i_step_data = o_step_left ? 4'(o_step_data << o_step_amt) : 4'(o_step_data >> o_step_amt);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // whole-command reference: result of one logical shift by the full amount
  function automatic logic [3:0] ref_shift(input logic left, input int amt, input logic [3:0] d);
    logic [31:0] w;
    w = {28'd0, d};
    w = left ? (w << amt) : (w >> amt);
    return w[3:0];
  endfunction

  task automatic run_cmd(input logic left, input int amt, input logic [3:0] data, input int hold);
    int a, p, cyc;
    logic [3:0] d, res;
    a = amt;
`ifdef SHIFT_SEQ_CLAMP_EN
    if (a > 4) a = 4;
`endif
    res = ref_shift(left, amt, data);
    d = data;
    chk("idle_ready", o_ready, 1);
    i_valid = 1; i_left = left; i_amt = 4'(amt); i_data = data;
    @(posedge i_clk); #1;
    i_valid = 0; i_left = 1'($urandom); i_amt = 4'($urandom); i_data = 4'($urandom);
    cyc = 1;
    while (a > 0) begin
      p = (a > 3) ? 3 : a;
      chk("step_valid", o_step_valid, 1);
      chk("step_amt", o_step_amt, p);
      chk("step_left", o_step_left, left);
      chk("step_data", o_step_data, d);
      chk("step_ready", o_ready, 0);
      chk("step_no_valid", o_valid, 0);
      d = left ? 4'(d << p) : 4'(d >> p);
      a -= p;
      cyc++;
      @(posedge i_clk); #1;
    end
    chk("done_valid", o_valid, 1);
    chk("done_data", o_data, res);
    chk("done_no_step", o_step_valid, 0);
    chk("done_step_amt", o_step_amt, 0);
    chk("done_ready", o_ready, 0);
    for (int k = 0; k < hold; k++) begin
      i_ready = 0; i_valid = 1'($urandom); i_data = 4'($urandom); i_amt = 4'($urandom);
      @(posedge i_clk); #1;
      chk("bp_valid", o_valid, 1);
      chk("bp_data", o_data, res);
      chk("bp_ready", o_ready, 0);
      chk("bp_no_step", o_step_valid, 0);
    end
    i_valid = 1; i_ready = 1; i_amt = 4'd1;
    @(posedge i_clk); #1;
    i_ready = 0;
    chk("after_valid", o_valid, 0);
    chk("after_ready", o_ready, 1);
    chk("after_no_step", o_step_valid, 0);
    i_valid = 0;
  endtask

  initial begin
    #2;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_step_valid", o_step_valid, 0);
    chk("rst_step_amt", o_step_amt, 0);
    chk("rst_step_left", o_step_left, 0);
    chk("rst_step_data", o_step_data, 0);
    @(posedge i_clk); #1;
    i_rst = 0;
    @(posedge i_clk); #1;
    chk("rel_ready", o_ready, 1);
    run_cmd(1, 2, 4'b0001, 0);
    run_cmd(0, 7, 4'b1111, 0);
    run_cmd(1, 7, 4'b0001, 0);
    run_cmd(1, 0, 4'b1011, 0);
    run_cmd(0, 1, 4'b1010, 5);
    run_cmd(1, 15, 4'b1001, 2);
    run_cmd(0, 3, 4'b1000, 0);
    run_cmd(1, 4, 4'b0001, 0);
    // reset in the middle of an amount-9 command
    i_valid = 1; i_left = 1; i_amt = 4'd9; i_data = 4'b0011;
    @(posedge i_clk); #1;
    i_valid = 0;
    chk("mid_step_valid", o_step_valid, 1);
    #2 i_rst = 1;
    #1;
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_step", o_step_valid, 0);
    chk("mid_rst_amt", o_step_amt, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_step_data", o_step_data, 0);
    @(posedge i_clk); #1;
    i_rst = 0;
    @(posedge i_clk); #1;
    chk("post_rst_valid", o_valid, 0);
    run_cmd(1, 1, 4'b0110, 0);
    for (int i = 0; i < 40; i++)
      run_cmd(1'($urandom), int'($urandom_range(0, 15)), 4'($urandom), int'($urandom_range(0, 3)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
